// File: rtl/ycr_arb_pkg.sv
// ycr_arb_pkg: shared types and constants for the icache port arbiter.
//   arb_state_e  : arbiter FSM states
//   ARB_GNT_*    : encodings of the grant / mux-select output
//   memif_resp_e : icache response codes (core memif encoding)
//   arb_winner() : fixed imem priority with dmem aging override
package ycr_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT,
    ARB_RESP
  } arb_state_e;

  localparam logic [1:0] ARB_GNT_IMEM = 2'b00;
  localparam logic [1:0] ARB_GNT_DMEM = 2'b01;
  localparam logic [1:0] ARB_GNT_NONE = 2'b11;

  typedef enum logic [1:0] {
    YCR_MEMIF_NOTRDY  = 2'b00,
    YCR_MEMIF_RDY_OK  = 2'b01,
    YCR_MEMIF_RDY_ER  = 2'b10,
    YCR_MEMIF_RDY_LOK = 2'b11
  } memif_resp_e;

  // imem wins unless dmem is alone or has waited long enough.
  function automatic logic [1:0] arb_winner(input logic imem, input logic dmem,
                                            input logic dmem_expired);
    return (dmem && (!imem || dmem_expired)) ? ARB_GNT_DMEM : ARB_GNT_IMEM;
  endfunction

endpackage

// File: rtl/ycr_arb_age_cnt.sv
// ycr_arb_age_cnt: saturating wait counter used to age the dmem requester.
//   clk     in  core clock
//   rst     in  synchronous active-high reset
//   inc     in  count one waiting cycle
//   clr     in  clear (wins over inc)
//   expired out counter has reached MAX_WAIT
module ycr_arb_age_cnt #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam int W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)                         r_cnt <= '0;
    else if (inc && (r_cnt != W'(MAX_WAIT))) r_cnt <= r_cnt + 1'b1;
  end

  // Counter parks at MAX_WAIT, so equality is enough.
  assign expired = (r_cnt == W'(MAX_WAIT));

endmodule

// File: rtl/ycr_icache_arb_ctrl.sv
// ycr_icache_arb_ctrl: sequencing arbiter for the shared icache port.
// imem (fetch) has fixed priority; dmem is aged so it cannot starve.
// The grant is held for the whole request/response transaction (until
// RDY_LOK or RDY_ER) and the next winner is picked on the same edge the
// transaction ends, so back-to-back transactions have no idle bubble.
// Optional feature macro: YCR_ARB_TIMEOUT_EN (abandon a transaction after
// TIMEOUT_CYC cycles with no ack / response progress, pulsing abort).
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   imem_req        fetch request pending
//   dmem_req        data request pending
//   icache_req_ack  icache accepted the granted request
//   icache_resp[1:0] NOTRDY / RDY_OK / RDY_ER / RDY_LOK
//   gnt[1:0]        mux select: 00 imem, 01 dmem, 11 none
//   busy            transaction in flight
//   abort           one-cycle timeout pulse
//   beat_cnt[7:0]   OK/LOK beats of the current transaction (saturating)
module ycr_icache_arb_ctrl
  import ycr_arb_pkg::*;
#(
  parameter int DMEM_MAX_WAIT = 8,
  parameter int TIMEOUT_CYC   = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       imem_req,
  input  logic       dmem_req,
  input  logic       icache_req_ack,
  input  logic [1:0] icache_resp,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       abort,
  output logic [7:0] beat_cnt
);

  arb_state_e r_state;
  logic [1:0] r_gnt;
  logic       r_busy;
  logic       r_abort;
  logic [7:0] r_beat;

  logic       w_any_req;
  logic       w_gnt_req;
  logic       w_terminal;
  logic       w_beat;
  logic [7:0] w_beat_nxt;
  logic [1:0] w_winner;
  logic       w_expired;
  logic       w_end;
  logic       w_dmem_pick;
  logic       w_to_fire;

  assign w_any_req  = imem_req | dmem_req;
  assign w_gnt_req  = (r_gnt == ARB_GNT_DMEM) ? dmem_req : imem_req;
  assign w_terminal = (icache_resp == YCR_MEMIF_RDY_LOK) || (icache_resp == YCR_MEMIF_RDY_ER);
  assign w_beat     = (icache_resp == YCR_MEMIF_RDY_OK)  || (icache_resp == YCR_MEMIF_RDY_LOK);
  assign w_beat_nxt = !w_beat ? r_beat : ((r_beat == 8'hFF) ? r_beat : r_beat + 8'd1);
  assign w_winner   = arb_winner(imem_req, dmem_req, w_expired);

  // Transaction completes this cycle (zero-wait hit in GNT included).
  assign w_end = ((r_state == ARB_GNT) && icache_req_ack && w_terminal) ||
                 ((r_state == ARB_RESP) && w_terminal);

  // dmem is being granted on this edge, which resets its age.
  assign w_dmem_pick = w_any_req && ((r_state == ARB_IDLE) || w_end) &&
                       (w_winner == ARB_GNT_DMEM);

  ycr_arb_age_cnt #(
    .MAX_WAIT (DMEM_MAX_WAIT)
  ) u_age (
    .clk     (clk),
    .rst     (rst),
    .inc     (dmem_req && (r_gnt != ARB_GNT_DMEM)),
    .clr     (!dmem_req || w_dmem_pick || (r_gnt == ARB_GNT_DMEM)),
    .expired (w_expired)
  );

`ifdef YCR_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [TW-1:0] r_to_cnt;
  logic          w_progress;

  assign w_progress = icache_req_ack || (icache_resp != YCR_MEMIF_NOTRDY);

  always_ff @(posedge clk) begin
    if (rst || (r_state == ARB_IDLE) || w_progress) r_to_cnt <= '0;
    else if (r_to_cnt != TW'(TIMEOUT_CYC - 1))      r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Fires on the cycle the counter sits at TIMEOUT_CYC-1 with still no progress.
  assign w_to_fire = (r_to_cnt == TW'(TIMEOUT_CYC - 1)) && !w_progress;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC > 0);
  assign w_to_fire        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_gnt   <= ARB_GNT_NONE;
      r_busy  <= 1'b0;
      r_abort <= 1'b0;
      r_beat  <= 8'd0;
    end else begin
      r_abort <= 1'b0;
      if ((r_state == ARB_IDLE) || w_end) begin
        // Arbitration point: idle, or the current transaction just ended.
        if (w_any_req) begin
          r_state <= ARB_GNT;
          r_gnt   <= w_winner;
          r_busy  <= 1'b1;
          r_beat  <= 8'd0;
        end else begin
          r_state <= ARB_IDLE;
          r_gnt   <= ARB_GNT_NONE;
          r_busy  <= 1'b0;
          if (r_state != ARB_IDLE) r_beat <= w_beat_nxt;
        end
      end else begin
        case (r_state)
          ARB_GNT: begin
            if (icache_req_ack) begin
              r_state <= ARB_RESP;
              r_beat  <= w_beat_nxt;
            end else if (!w_gnt_req || w_to_fire) begin
              // Requester gave up before ack, or timeout: drop the grant.
              r_state <= ARB_IDLE;
              r_gnt   <= ARB_GNT_NONE;
              r_busy  <= 1'b0;
              r_abort <= w_gnt_req;
            end
          end
          ARB_RESP: begin
            if (w_beat) begin
              r_beat <= w_beat_nxt;
            end else if (w_to_fire) begin
              r_state <= ARB_IDLE;
              r_gnt   <= ARB_GNT_NONE;
              r_busy  <= 1'b0;
              r_abort <= 1'b1;
            end
          end
          default: begin
            r_state <= ARB_IDLE;
            r_gnt   <= ARB_GNT_NONE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gnt      = r_gnt;
  assign busy     = r_busy;
  assign abort    = r_abort;
  assign beat_cnt = r_beat;

endmodule

// File: tb/tb_ycr_icache_arb_ctrl.sv
module tb_ycr_icache_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req, dmem_req, icache_req_ack;
  logic [1:0] icache_resp;
  logic [1:0] gnt;
  logic       busy, abort;
  logic [7:0] beat_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  ycr_icache_arb_ctrl #(
    .DMEM_MAX_WAIT (8),
    .TIMEOUT_CYC   (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .dmem_req       (dmem_req),
    .icache_req_ack (icache_req_ack),
    .icache_resp    (icache_resp),
    .gnt            (gnt),
    .busy           (busy),
    .abort          (abort),
    .beat_cnt       (beat_cnt)
  );

  typedef struct {
    logic       imem, dmem, ack;
    logic [1:0] resp;
    logic [1:0] gnt;
    logic       busy;
    logic [7:0] beat;
  } vec_t;

  function automatic vec_t mk(input logic im, input logic dm, input logic ak,
                              input logic [1:0] rs, input logic [1:0] g,
                              input logic b, input logic [7:0] bc);
    vec_t v;
    v.imem = im; v.dmem = dm; v.ack = ak; v.resp = rs;
    v.gnt = g; v.busy = b; v.beat = bc;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic im, input logic dm, input logic ak, input logic [1:0] rs);
    imem_req = im; dmem_req = dm; icache_req_ack = ak; icache_resp = rs;
  endtask

  vec_t vecs[20];

  initial begin
    // imem alone: grant, ack, OK x3, LOK, stray response in idle
    vecs[0]  = mk(1,0,0,2'b00, 2'b00,1,8'd0);
    vecs[1]  = mk(1,0,1,2'b00, 2'b00,1,8'd0);
    vecs[2]  = mk(1,0,0,2'b01, 2'b00,1,8'd1);
    vecs[3]  = mk(1,0,0,2'b01, 2'b00,1,8'd2);
    vecs[4]  = mk(1,0,0,2'b01, 2'b00,1,8'd3);
    vecs[5]  = mk(0,0,0,2'b11, 2'b11,0,8'd4);
    vecs[6]  = mk(0,0,0,2'b01, 2'b11,0,8'd4);
    // zero-wait hit (ack + LOK together), stray ack in idle
    vecs[7]  = mk(0,1,0,2'b00, 2'b01,1,8'd0);
    vecs[8]  = mk(0,0,1,2'b11, 2'b11,0,8'd1);
    vecs[9]  = mk(0,0,1,2'b00, 2'b11,0,8'd1);
    // dmem RDY_ER with imem pending: straight back to GNT for imem
    vecs[10] = mk(0,1,0,2'b00, 2'b01,1,8'd0);
    vecs[11] = mk(1,1,1,2'b00, 2'b01,1,8'd0);
    vecs[12] = mk(1,1,0,2'b01, 2'b01,1,8'd1);
    vecs[13] = mk(1,0,0,2'b10, 2'b00,1,8'd0);
    vecs[14] = mk(1,0,1,2'b00, 2'b00,1,8'd0);
    vecs[15] = mk(0,0,0,2'b11, 2'b11,0,8'd1);
    // request withdrawn before ack
    vecs[16] = mk(1,0,0,2'b00, 2'b00,1,8'd0);
    vecs[17] = mk(0,0,0,2'b00, 2'b11,0,8'd0);
    // simultaneous requests, fresh dmem: imem priority; then withdraw
    vecs[18] = mk(1,1,0,2'b00, 2'b00,1,8'd0);
    vecs[19] = mk(0,0,0,2'b00, 2'b11,0,8'd0);

    rst = 1'b1;
    drive(0,0,0,2'b00);
    tick(); tick();
    chk("reset gnt",   {6'd0, gnt},  8'h03);
    chk("reset busy",  {7'd0, busy}, 8'h00);
    chk("reset abort", {7'd0, abort}, 8'h00);
    chk("reset beat",  beat_cnt,     8'h00);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].imem, vecs[i].dmem, vecs[i].ack, vecs[i].resp);
      tick();
      chk($sformatf("v%0d gnt", i),   {6'd0, gnt},   {6'd0, vecs[i].gnt});
      chk($sformatf("v%0d busy", i),  {7'd0, busy},  {7'd0, vecs[i].busy});
      chk($sformatf("v%0d beat", i),  beat_cnt,      vecs[i].beat);
      chk($sformatf("v%0d abort", i), {7'd0, abort}, 8'h00);
    end

    // Aging: both request continuously; dmem wins once imem's burst ends.
    drive(1,1,0,2'b00);
    tick();
    chk("age first gnt", {6'd0, gnt}, 8'h00);
    drive(1,1,1,2'b00);
    tick();
    drive(1,1,0,2'b01);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("age hold %0d", i), {6'd0, gnt}, 8'h00);
    end
    chk("age beats", beat_cnt, 8'd8);
    drive(1,1,0,2'b11);
    tick();
    chk("age dmem gnt",  {6'd0, gnt},  8'h01);
    chk("age dmem busy", {7'd0, busy}, 8'h01);
    chk("age dmem beat", beat_cnt,     8'h00);
    drive(1,1,1,2'b11);
    tick();
    chk("age back imem", {6'd0, gnt}, 8'h00);
    drive(0,0,0,2'b00);
    tick();
    chk("age drop gnt", {6'd0, gnt}, 8'h03);

    // Reset in RESP with dmem granted
    drive(0,1,0,2'b00);
    tick();
    drive(0,1,1,2'b00);
    tick();
    drive(0,1,0,2'b01);
    tick();
    chk("pre-rst gnt",  {6'd0, gnt}, 8'h01);
    chk("pre-rst beat", beat_cnt,    8'h01);
    rst = 1'b1;
    tick();
    chk("rst gnt",   {6'd0, gnt},   8'h03);
    chk("rst busy",  {7'd0, busy},  8'h00);
    chk("rst abort", {7'd0, abort}, 8'h00);
    chk("rst beat",  beat_cnt,      8'h00);
    rst = 1'b0;
    drive(0,0,0,2'b00);
    tick();

    // Stalled response stream
    drive(1,0,0,2'b00);
    tick();
    drive(1,0,1,2'b00);
    tick();
    drive(1,0,0,2'b00);
`ifdef YCR_ARB_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("to abort %0d", i), {7'd0, abort}, (i == 16) ? 8'h01 : 8'h00);
      chk($sformatf("to gnt %0d", i),   {6'd0, gnt},   (i == 16) ? 8'h03 : 8'h00);
    end
    drive(0,0,0,2'b00);
    tick();
    chk("to abort clr", {7'd0, abort}, 8'h00);
    chk("to idle gnt",  {6'd0, gnt},   8'h03);
`else
    for (int i = 1; i <= 20; i++) tick();
    chk("stall abort", {7'd0, abort}, 8'h00);
    chk("stall gnt",   {6'd0, gnt},   8'h00);
    chk("stall busy",  {7'd0, busy},  8'h01);
    drive(0,0,0,2'b11);
    tick();
    chk("stall end gnt",  {6'd0, gnt}, 8'h03);
    chk("stall end beat", beat_cnt,    8'h01);
    drive(0,0,0,2'b00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
